// File: rtl/ysyx_22041207_lsu.sv
// Memory-stage load/store unit: one bus transaction per memory op, load alignment/extension, pipeline stall.
// Optional LSU_MISALIGN_CHECK_EN adds misalign_o and suppresses bus access for unaligned ops.
module ysyx_22041207_lsu #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid_i,
    input  logic        mem_read_i,
    input  logic [3:0]  read_num_i,
    input  logic [7:0]  write_mask_i,
    input  logic        sext_i,
    input  logic [63:0] addr_i,
    input  logic [63:0] wdata_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [63:0] load_data_o,
    output logic        bus_err_o,
    output logic        bus_req_valid_o,
    input  logic        bus_req_ready_i,
    output logic [63:0] bus_req_addr_o,
    output logic        bus_req_wen_o,
    output logic [63:0] bus_req_wdata_o,
    output logic [7:0]  bus_req_wmask_o,
    input  logic        bus_resp_valid_i,
    input  logic [63:0] bus_resp_rdata_i
`ifdef LSU_MISALIGN_CHECK_EN
    ,
    output logic        misalign_o
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [31:0] TO_LAST = (TIMEOUT_CYC == 0) ? 32'd0 : 32'(TIMEOUT_CYC - 1);

    logic [1:0]  state_reg;
    logic        is_load_reg;
    logic        sext_reg;
    logic [3:0]  read_num_reg;
    logic [2:0]  off_reg;
    logic [63:0] addr_reg;
    logic [63:0] wdata_reg;
    logic [7:0]  wmask_reg;
    logic        killed_reg;
    logic        err_reg;
    logic [31:0] cnt_reg;
    logic [63:0] load_data_reg;

    logic        mem_op;
    logic        timeout_hit;
    logic        misaligned;
    logic [63:0] rd_shifted;
    logic [63:0] rd_ext;

    assign mem_op      = op_valid_i && (mem_read_i || (write_mask_i != 8'd0));
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_reg == TO_LAST);

`ifdef LSU_MISALIGN_CHECK_EN
    logic       misalign_reg;
    logic [3:0] acc_size;

    assign acc_size = mem_read_i ? read_num_i : 4'($countones(write_mask_i));

    always_comb begin
        misaligned = 1'b0;
        case (acc_size)
            4'd1:    misaligned = 1'b0;
            4'd2:    misaligned = addr_i[0];
            4'd4:    misaligned = |addr_i[1:0];
            default: misaligned = |addr_i[2:0];
        endcase
    end

    assign misalign_o = (state_reg == S_DONE) && misalign_reg;
`else
    assign misaligned = 1'b0;
`endif

    // Bytes shifted past the doubleword top arrive as zero, so spans crossing it are zero-filled.
    assign rd_shifted = bus_resp_rdata_i >> {off_reg, 3'b000};

    always_comb begin
        rd_ext = 64'd0;
        case (read_num_reg)
            4'd1:    rd_ext = {{56{sext_reg & rd_shifted[7]}},  rd_shifted[7:0]};
            4'd2:    rd_ext = {{48{sext_reg & rd_shifted[15]}}, rd_shifted[15:0]};
            4'd4:    rd_ext = {{32{sext_reg & rd_shifted[31]}}, rd_shifted[31:0]};
            default: rd_ext = rd_shifted;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            is_load_reg   <= 1'b0;
            sext_reg      <= 1'b0;
            read_num_reg  <= 4'd0;
            off_reg       <= 3'd0;
            addr_reg      <= 64'd0;
            wdata_reg     <= 64'd0;
            wmask_reg     <= 8'd0;
            killed_reg    <= 1'b0;
            err_reg       <= 1'b0;
            cnt_reg       <= 32'd0;
            load_data_reg <= 64'd0;
`ifdef LSU_MISALIGN_CHECK_EN
            misalign_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    err_reg <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
                    misalign_reg <= 1'b0;
`endif
                    if (mem_op && !flush_i) begin
                        // A load takes precedence over any store mask presented with it.
                        is_load_reg  <= mem_read_i;
                        sext_reg     <= sext_i;
                        read_num_reg <= read_num_i;
                        off_reg      <= addr_i[2:0];
                        addr_reg     <= {addr_i[63:3], 3'b000};
                        wdata_reg    <= mem_read_i ? 64'd0 : (wdata_i << {addr_i[2:0], 3'b000});
                        wmask_reg    <= mem_read_i ? 8'd0 : (write_mask_i << addr_i[2:0]);
                        killed_reg   <= 1'b0;
                        cnt_reg      <= 32'd0;
                        if (misaligned) begin
                            state_reg <= S_DONE;
`ifdef LSU_MISALIGN_CHECK_EN
                            misalign_reg <= 1'b1;
`endif
                        end else begin
                            state_reg <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus_req_ready_i) begin
                        state_reg  <= S_WAIT;
                        cnt_reg    <= 32'd0;
                        killed_reg <= flush_i;
                    end else if (flush_i) begin
                        state_reg <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    cnt_reg <= cnt_reg + 32'd1;
                    if (bus_resp_valid_i || timeout_hit) begin
                        // A killed op must still drain its bus transaction before retiring silently.
                        if (killed_reg || flush_i) begin
                            state_reg <= S_IDLE;
                        end else begin
                            state_reg <= S_DONE;
                            if (!bus_resp_valid_i) begin
                                err_reg       <= 1'b1;
                                load_data_reg <= 64'd0;
                            end else if (is_load_reg) begin
                                load_data_reg <= rd_ext;
                            end
                        end
                    end else if (flush_i) begin
                        killed_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign stall_o         = !rst && (((state_reg == S_IDLE) && mem_op) ||
                                      (state_reg == S_REQ) || (state_reg == S_WAIT));
    assign done_o          = (state_reg == S_DONE);
    assign bus_err_o       = (state_reg == S_DONE) && err_reg;
    assign load_data_o     = load_data_reg;
    assign bus_req_valid_o = (state_reg == S_REQ);
    assign bus_req_addr_o  = addr_reg;
    assign bus_req_wen_o   = !is_load_reg && (wmask_reg != 8'd0);
    assign bus_req_wdata_o = wdata_reg;
    assign bus_req_wmask_o = wmask_reg;

endmodule

// File: tb/tb_ysyx_22041207_lsu.sv
// Scoreboard bench for ysyx_22041207_lsu: expected bus requests and completions are queued by the
// stimulus process and checked by an independent monitor on the falling clock edge.
module tb_ysyx_22041207_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid_i = 1'b0;
    logic        mem_read_i = 1'b0;
    logic [3:0]  read_num_i = 4'd0;
    logic [7:0]  write_mask_i = 8'd0;
    logic        sext_i = 1'b0;
    logic [63:0] addr_i = 64'd0;
    logic [63:0] wdata_i = 64'd0;
    logic        flush_i = 1'b0;
    logic        stall_o;
    logic        done_o;
    logic [63:0] load_data_o;
    logic        bus_err_o;
    logic        bus_req_valid_o;
    logic        bus_req_ready_i = 1'b0;
    logic [63:0] bus_req_addr_o;
    logic        bus_req_wen_o;
    logic [63:0] bus_req_wdata_o;
    logic [7:0]  bus_req_wmask_o;
    logic        bus_resp_valid_i = 1'b0;
    logic [63:0] bus_resp_rdata_i = 64'd0;

    ysyx_22041207_lsu #(.TIMEOUT_CYC(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .op_valid_i       (op_valid_i),
        .mem_read_i       (mem_read_i),
        .read_num_i       (read_num_i),
        .write_mask_i     (write_mask_i),
        .sext_i           (sext_i),
        .addr_i           (addr_i),
        .wdata_i          (wdata_i),
        .flush_i          (flush_i),
        .stall_o          (stall_o),
        .done_o           (done_o),
        .load_data_o      (load_data_o),
        .bus_err_o        (bus_err_o),
        .bus_req_valid_o  (bus_req_valid_o),
        .bus_req_ready_i  (bus_req_ready_i),
        .bus_req_addr_o   (bus_req_addr_o),
        .bus_req_wen_o    (bus_req_wen_o),
        .bus_req_wdata_o  (bus_req_wdata_o),
        .bus_req_wmask_o  (bus_req_wmask_o),
        .bus_resp_valid_i (bus_resp_valid_i),
        .bus_resp_rdata_i (bus_resp_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } req_t;

    typedef struct {
        logic        err;
        logic [63:0] data;
    } cpl_t;

    req_t req_q[$];
    cpl_t cpl_q[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_done = 0;
    int   done_cnt = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_req(input logic [63:0] a, input logic w, input logic [63:0] d, input logic [7:0] m);
        req_t r;
        r.addr = a; r.wen = w; r.wdata = d; r.wmask = m;
        req_q.push_back(r);
    endtask

    task automatic push_cpl(input logic e, input logic [63:0] d);
        cpl_t c;
        c.err = e; c.data = d;
        cpl_q.push_back(c);
        exp_done++;
    endtask

    // Monitor: request fields checked every REQ cycle (stability), popped on handshake; completions popped on done_o.
    always @(negedge clk) begin
        if (bus_req_valid_o) begin
            if (req_q.size() == 0) begin
                chk("unexpected_req", 64'd1, 64'd0);
            end else begin
                chk("req_addr",  bus_req_addr_o,         req_q[0].addr);
                chk("req_wen",   64'(bus_req_wen_o),     64'(req_q[0].wen));
                chk("req_wdata", bus_req_wdata_o,        req_q[0].wdata);
                chk("req_wmask", 64'(bus_req_wmask_o),   64'(req_q[0].wmask));
                if (bus_req_ready_i) begin
                    $display("req handshake addr=%h wen=%0d wdata=%h wmask=%h",
                             bus_req_addr_o, bus_req_wen_o, bus_req_wdata_o, bus_req_wmask_o);
                    void'(req_q.pop_front());
                end
            end
        end
        if (done_o) begin
            done_cnt++;
            chk("done_width", 64'(prev_done), 64'd0);
            if (cpl_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                cpl_t c;
                c = cpl_q.pop_front();
                $display("completion err=%0d load_data=%h", bus_err_o, load_data_o);
                chk("cpl_err",  64'(bus_err_o), 64'(c.err));
                chk("cpl_data", load_data_o,    c.data);
                chk("cpl_stall", 64'(stall_o),  64'd0);
            end
        end
        prev_done = done_o;
    end

    // mode: 0 normal, 1 flush in WAIT_RESP, 2 no response (timeout), 3 reset in WAIT_RESP
    task automatic run_op(input logic rd, input logic [3:0] rn, input logic [7:0] mask, input logic sx,
                          input logic [63:0] addr, input logic [63:0] wd, input int rdy_dly,
                          input int resp_dly, input logic [63:0] rdata, input int mode);
        @(posedge clk); #1;
        op_valid_i = 1'b1; mem_read_i = rd; read_num_i = rn; write_mask_i = mask;
        sext_i = sx; addr_i = addr; wdata_i = wd;
        #1 chk("stall_accept", 64'(stall_o), 64'd1);
        @(posedge clk); #1;
        op_valid_i = 1'b0; mem_read_i = 1'b0; write_mask_i = 8'd0;
        for (int i = 0; i < rdy_dly; i++) begin
            #1 chk("stall_req", 64'(stall_o), 64'd1);
            @(posedge clk); #1;
        end
        bus_req_ready_i = 1'b1;
        @(posedge clk); #1;
        bus_req_ready_i = 1'b0;
        if (mode == 3) begin
            rst = 1'b1;
            #1;
            chk("rst_stall",     64'(stall_o),         64'd0);
            chk("rst_done",      64'(done_o),          64'd0);
            chk("rst_req_valid", 64'(bus_req_valid_o), 64'd0);
            chk("rst_load_data", load_data_o,          64'd0);
            chk("rst_req_addr",  bus_req_addr_o,       64'd0);
            @(posedge clk); #1;
            rst = 1'b0;
        end else if (mode == 1) begin
            flush_i = 1'b1;
            @(posedge clk); #1;
            flush_i = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            bus_resp_valid_i = 1'b1; bus_resp_rdata_i = rdata;
            @(posedge clk); #1;
            bus_resp_valid_i = 1'b0;
            #1;
            chk("flush_stall", 64'(stall_o), 64'd0);
            chk("flush_done",  64'(done_o),  64'd0);
        end else if (mode == 2) begin
            repeat (6) @(posedge clk);
            #1;
        end else begin
            for (int i = 0; i < resp_dly; i++) begin
                #1 chk("stall_wait", 64'(stall_o), 64'd1);
                @(posedge clk); #1;
            end
            bus_resp_valid_i = 1'b1; bus_resp_rdata_i = rdata;
            #1 chk("stall_ack", 64'(stall_o), 64'd1);
            @(posedge clk); #1;
            bus_resp_valid_i = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1;
        chk("reset_stall",     64'(stall_o),         64'd0);
        chk("reset_done",      64'(done_o),          64'd0);
        chk("reset_load_data", load_data_o,          64'd0);
        chk("reset_req_valid", 64'(bus_req_valid_o), 64'd0);
        chk("reset_bus_err",   64'(bus_err_o),       64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // lb sext, off 5
        push_req(64'h8000_0000, 1'b0, 64'd0, 8'h00);
        push_cpl(1'b0, 64'hFFFF_FFFF_FFFF_FF80);
        run_op(1'b1, 4'd1, 8'h00, 1'b1, 64'h8000_0005, 64'd0, 0, 1, 64'h0000_8000_0000_0000, 0);

        // sw at off 4; load data unchanged
        push_req(64'h8000_0000, 1'b1, 64'h1122_3344_0000_0000, 8'hF0);
        push_cpl(1'b0, 64'hFFFF_FFFF_FFFF_FF80);
        run_op(1'b0, 4'd0, 8'h0F, 1'b0, 64'h8000_0004, 64'h1122_3344, 0, 2, 64'd0, 0);

        // lhu with 5 cycles of backpressure
        push_req(64'h8000_0010, 1'b0, 64'd0, 8'h00);
        push_cpl(1'b0, 64'h0000_0000_0000_9ABC);
        run_op(1'b1, 4'd2, 8'h00, 1'b0, 64'h8000_0012, 64'd0, 5, 0, 64'h1234_5678_9ABC_DEF0, 0);

        // lw sext, off 4
        push_req(64'h1000, 1'b0, 64'd0, 8'h00);
        push_cpl(1'b0, 64'hFFFF_FFFF_8765_4321);
        run_op(1'b1, 4'd4, 8'h00, 1'b1, 64'h1004, 64'd0, 1, 1, 64'h8765_4321_0000_0000, 0);

        // ld with a store mask also present: load wins
        push_req(64'h2000, 1'b0, 64'd0, 8'h00);
        push_cpl(1'b0, 64'hDEAD_BEEF_CAFE_F00D);
        run_op(1'b1, 4'd8, 8'hFF, 1'b0, 64'h2000, 64'd0, 0, 0, 64'hDEAD_BEEF_CAFE_F00D, 0);

        // lw sext at off 6: upper bytes zero-filled before extension
        push_req(64'h4000, 1'b0, 64'd0, 8'h00);
        push_cpl(1'b0, 64'h0000_0000_0000_AABB);
        run_op(1'b1, 4'd4, 8'h00, 1'b1, 64'h4006, 64'd0, 0, 0, 64'hAABB_CCDD_EEFF_0011, 0);

        // sd at off 4: mask and data truncated
        push_req(64'h5000, 1'b1, 64'h0506_0708_0000_0000, 8'hF0);
        push_cpl(1'b0, 64'h0000_0000_0000_AABB);
        run_op(1'b0, 4'd0, 8'hFF, 1'b0, 64'h5004, 64'h0102_0304_0506_0708, 0, 0, 64'd0, 0);

        // flush in WAIT_RESP: no completion, data kept
        push_req(64'h6000, 1'b0, 64'd0, 8'h00);
        run_op(1'b1, 4'd8, 8'h00, 1'b0, 64'h6000, 64'd0, 0, 0, 64'h1111_2222_3333_4444, 1);
        chk("flush_keep_data", load_data_o, 64'h0000_0000_0000_AABB);

        // flush in REQ before handshake
        push_req(64'h3000, 1'b0, 64'd0, 8'h00);
        @(posedge clk); #1;
        op_valid_i = 1'b1; mem_read_i = 1'b1; read_num_i = 4'd8; addr_i = 64'h3000;
        @(posedge clk); #1;
        op_valid_i = 1'b0; mem_read_i = 1'b0; flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        #1;
        chk("flush_req_valid", 64'(bus_req_valid_o), 64'd0);
        chk("flush_req_stall", 64'(stall_o),         64'd0);
        void'(req_q.pop_front());

        // flush in IDLE blocks acceptance; stray response ignored
        op_valid_i = 1'b1; mem_read_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        op_valid_i = 1'b0; mem_read_i = 1'b0; flush_i = 1'b0;
        bus_resp_valid_i = 1'b1; bus_resp_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 chk("flush_idle_req", 64'(bus_req_valid_o), 64'd0);
        @(posedge clk); #1;
        bus_resp_valid_i = 1'b0;
        @(posedge clk); #1;
        chk("stray_resp_data", load_data_o, 64'h0000_0000_0000_AABB);

        // timeout after 4 cycles without response
        push_req(64'h7000, 1'b0, 64'd0, 8'h00);
        push_cpl(1'b1, 64'd0);
        run_op(1'b1, 4'd8, 8'h00, 1'b0, 64'h7000, 64'd0, 0, 0, 64'd0, 2);

        // lbu off 1
        push_req(64'h8000, 1'b0, 64'd0, 8'h00);
        push_cpl(1'b0, 64'h0000_0000_0000_005A);
        run_op(1'b1, 4'd1, 8'h00, 1'b0, 64'h8001, 64'd0, 0, 1, 64'h0000_0000_0000_5A00, 0);

        // reset during WAIT_RESP
        push_req(64'h9000, 1'b0, 64'd0, 8'h00);
        run_op(1'b1, 4'd8, 8'h00, 1'b0, 64'h9000, 64'd0, 0, 0, 64'd0, 3);

        // lh sext at off 6 after reset
        push_req(64'hA000, 1'b0, 64'd0, 8'h00);
        push_cpl(1'b0, 64'hFFFF_FFFF_FFFF_F00D);
        run_op(1'b1, 4'd2, 8'h00, 1'b1, 64'hA006, 64'd0, 0, 0, 64'hF00D_0000_0000_0000, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("req_queue_empty", 64'(req_q.size()), 64'd0);
        chk("cpl_queue_empty", 64'(cpl_q.size()), 64'd0);
        chk("done_count",      64'(done_cnt),     64'(exp_done));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
